// File: rtl/msk_hpc2_and_sched.sv
// Round-robin scheduler that shares one HPC2 masked AND gadget (latency 2) between
// N_REQ requesters, applies the a/b input skew and returns tagged results in issue order.
module msk_hpc2_and_sched #(
  parameter int d          = 2,
  parameter int N_REQ      = 2,
  parameter int FIFO_DEPTH = 4,
  parameter int RND_W      = d * (d - 1) / 2,
  localparam int ID_W      = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]   req_valid,
  output logic [N_REQ-1:0]   req_ready,
  input  logic [N_REQ*d-1:0] req_ina,
  input  logic [N_REQ*d-1:0] req_inb,
  input  logic               rnd_valid,
  output logic               rnd_ready,
  input  logic [RND_W-1:0]   rnd_in,
  output logic [d-1:0]       g_ina,
  output logic [d-1:0]       g_inb,
  output logic [RND_W-1:0]   g_rnd,
  input  logic [d-1:0]       g_out,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [ID_W-1:0]    rsp_id,
  output logic [d-1:0]       rsp_data
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int OCC_W = CNT_W + 1;

  // Handshakes: a transfer happens in a cycle where valid and ready are both high;
  // ready never depends on the same cycle's dequeue, and is low during reset.

  logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic                v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
  logic [ID_W-1:0]     id1_q, id1_d, id2_q, id2_d, id3_q, id3_d;
  logic [d-1:0]        inb1_q, inb1_d;
  logic [d-1:0]        g_ina_q, g_ina_d, g_inb_q, g_inb_d;
  logic [RND_W-1:0]    g_rnd_q, g_rnd_d;
  logic [ID_W+d-1:0]   mem_q [FIFO_DEPTH];
  logic [ID_W+d-1:0]   mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic                gnt_found;
  logic [ID_W-1:0]     gnt_idx;
  logic [N_REQ-1:0]    gnt_vec;
  int                  srch_idx;
  logic [OCC_W-1:0]    occ;
  logic                credit, issue, push, pop;

  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    gnt_vec   = '0;
    srch_idx  = 0;
    for (int k = 0; k < N_REQ; k++) begin
      srch_idx = (int'(rr_ptr_q) + k) % N_REQ;
      if (!gnt_found && req_valid[srch_idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = ID_W'(srch_idx);
      end
    end
    if (gnt_found) gnt_vec[gnt_idx] = 1'b1;
  end

  // Credit counts every job not yet popped, so a full FIFO can never overflow.
  always_comb begin
    occ       = OCC_W'(v1_q) + OCC_W'(v2_q) + OCC_W'(v3_q) + OCC_W'(cnt_q);
    credit    = occ < OCC_W'(FIFO_DEPTH);
    issue     = rst_n & gnt_found & rnd_valid & credit;
    req_ready = rst_n ? (gnt_vec & {N_REQ{rnd_valid & credit}}) : '0;
    rnd_ready = issue;
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (issue) rr_ptr_d = (gnt_idx == ID_W'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
    v1_d    = issue;
    id1_d   = issue ? gnt_idx : '0;
    g_ina_d = issue ? req_ina[int'(gnt_idx)*d +: d] : '0;
    inb1_d  = issue ? req_inb[int'(gnt_idx)*d +: d] : '0;
    g_rnd_d = issue ? rnd_in : '0;
    v2_d    = v1_q;
    id2_d   = id1_q;
    g_inb_d = v1_q ? inb1_q : '0;
    v3_d    = v2_q;
    id3_d   = id2_q;
  end

  always_comb begin
    push   = v3_q;
    pop    = rsp_valid & rsp_ready;
    mem_d  = mem_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (push) begin
      mem_d[wptr_q] = {id3_q, g_out};
      wptr_d        = wptr_q + 1'b1;
    end
    if (pop) rptr_d = rptr_q + 1'b1;
    if (push && !pop) cnt_d = cnt_q + 1'b1;
    else if (pop && !push) cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q <= '0;
      v1_q     <= 1'b0;
      v2_q     <= 1'b0;
      v3_q     <= 1'b0;
      id1_q    <= '0;
      id2_q    <= '0;
      id3_q    <= '0;
      inb1_q   <= '0;
      g_ina_q  <= '0;
      g_inb_q  <= '0;
      g_rnd_q  <= '0;
      mem_q    <= '{default: '0};
      wptr_q   <= '0;
      rptr_q   <= '0;
      cnt_q    <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      v1_q     <= v1_d;
      v2_q     <= v2_d;
      v3_q     <= v3_d;
      id1_q    <= id1_d;
      id2_q    <= id2_d;
      id3_q    <= id3_d;
      inb1_q   <= inb1_d;
      g_ina_q  <= g_ina_d;
      g_inb_q  <= g_inb_d;
      g_rnd_q  <= g_rnd_d;
      mem_q    <= mem_d;
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      cnt_q    <= cnt_d;
    end
  end

  assign g_ina              = g_ina_q;
  assign g_inb              = g_inb_q;
  assign g_rnd              = g_rnd_q;
  assign rsp_valid          = (cnt_q != '0);
  assign {rsp_id, rsp_data} = mem_q[rptr_q];

endmodule

// File: tb/tb_msk_hpc2_and_sched.sv
// Bench for msk_hpc2_and_sched: behavioural HPC2 gadget, round-robin/credit reference
// model with an expected-result queue, directed vectors and multi-cycle sequences.
module tb_msk_hpc2_and_sched;
  localparam int D  = 2;
  localparam int NR = 2;
  localparam int RW = 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NR-1:0] req_valid, req_ready;
  logic [NR*D-1:0] req_ina, req_inb;
  logic          rnd_valid, rnd_ready;
  logic [RW-1:0] rnd_in;
  logic [D-1:0]  g_ina, g_inb, g_out;
  logic [RW-1:0] g_rnd;
  logic          rsp_valid, rsp_ready;
  logic [0:0]    rsp_id;
  logic [D-1:0]  rsp_data;

  always #5 clk = ~clk;

  msk_hpc2_and_sched #(.d(D), .N_REQ(NR), .FIFO_DEPTH(4), .RND_W(RW)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_ina(req_ina), .req_inb(req_inb), .rnd_valid(rnd_valid), .rnd_ready(rnd_ready),
    .rnd_in(rnd_in), .g_ina(g_ina), .g_inb(g_inb), .g_rnd(g_rnd), .g_out(g_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data)
  );

  // Gadget model: a and r taken one cycle before b, output sharing one cycle after b.
  logic [D-1:0]  ga_s = '0;
  logic [RW-1:0] gr_s = '0;
  initial g_out = '0;
  always @(posedge clk) begin
    ga_s  <= g_ina;
    gr_s  <= g_rnd;
    g_out <= {gr_s[0], ((^ga_s) & (^g_inb)) ^ gr_s[0]};
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: entries are {id, a&b} for every issued, not yet popped job.
  logic [1:0] exp_q[$];
  logic [0:0] iss_ids[$];
  logic [0:0] rsp_ids[$];
  int         mptr = 0;
  int         issues = 0;
  int         rnds = 0;
  int         m_gid;
  logic       m_can;
  logic [1:0] m_eg, m_e;

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      mptr = 0;
    end else begin
      m_gid = -1;
      for (int k = 0; k < NR; k++)
        if (m_gid < 0 && req_valid[(mptr + k) % NR]) m_gid = (mptr + k) % NR;
      m_can = (m_gid >= 0) && rnd_valid && (exp_q.size() < 4);
      m_eg  = m_can ? (2'b01 << m_gid) : 2'b00;
      chk("req_ready", 32'(req_ready), 32'(m_eg));
      chk("rnd_ready", 32'(rnd_ready), 32'(m_can));
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          chk("rsp_unexpected", 32'(rsp_valid), 32'd0);
        end else begin
          m_e = exp_q.pop_front();
          chk("rsp_id", 32'(rsp_id), 32'(m_e[1]));
          chk("rsp_xor", 32'(^rsp_data), 32'(m_e[0]));
          rsp_ids.push_back(rsp_id);
        end
      end
      if (m_can) begin
        exp_q.push_back({m_gid[0], (^req_ina[m_gid*D +: D]) & (^req_inb[m_gid*D +: D])});
        iss_ids.push_back(m_gid[0]);
        mptr = (m_gid + 1) % NR;
        issues++;
      end
      if (rnd_ready) rnds++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle_inputs();
    req_valid = '0;
    rnd_valid = 1'b0;
    req_ina   = '0;
    req_inb   = '0;
    rnd_in    = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_inputs();
    rsp_ready = 1'b1;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic drive_job(input int id, input logic [1:0] a, input logic [1:0] b, input logic r);
    req_valid = 2'b01 << id;
    req_ina   = 4'(a) << (id * D);
    req_inb   = 4'(b) << (id * D);
    rnd_in    = r;
    rnd_valid = 1'b1;
  endtask

  typedef struct {
    int         id;
    logic [1:0] ina;
    logic [1:0] inb;
    logic       rnd;
    logic       exp_x;
  } vec_t;

  vec_t vt[6];
  int   base_iss, base_rnd, base_rsp, cyc;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    vt[0] = '{0, 2'b10, 2'b01, 1'b1, 1'b1};
    vt[1] = '{0, 2'b10, 2'b00, 1'b1, 1'b0};
    vt[2] = '{1, 2'b11, 2'b01, 1'b0, 1'b0};
    vt[3] = '{1, 2'b01, 2'b10, 1'b1, 1'b1};
    vt[4] = '{0, 2'b00, 2'b11, 1'b0, 1'b0};
    vt[5] = '{1, 2'b11, 2'b11, 1'b1, 1'b0};

    rst_n = 1'b0;
    idle_inputs();
    rsp_ready = 1'b1;
    #1;
    chk("rst_g_ina", 32'(g_ina), 0);
    chk("rst_g_inb", 32'(g_inb), 0);
    chk("rst_g_rnd", 32'(g_rnd), 0);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_rsp_data", 32'({rsp_id, rsp_data}), 0);
    req_valid = 2'b11;
    rnd_valid = 1'b1;
    #1;
    chk("rst_req_ready", 32'(req_ready), 0);
    chk("rst_rnd_ready", 32'(rnd_ready), 0);
    do_reset();

    // Single-job vectors: check the full A..A+4 timeline.
    for (int i = 0; i < 6; i++) begin
      tick();
      drive_job(vt[i].id, vt[i].ina, vt[i].inb, vt[i].rnd);
      #1;
      chk("vec_req_ready", 32'(req_ready), 32'(2'b01 << vt[i].id));
      tick();
      idle_inputs();
      chk("vec_g_ina", 32'(g_ina), 32'(vt[i].ina));
      chk("vec_g_rnd", 32'(g_rnd), 32'(vt[i].rnd));
      chk("vec_g_inb_early", 32'(g_inb), 0);
      tick();
      chk("vec_g_inb", 32'(g_inb), 32'(vt[i].inb));
      chk("vec_g_ina_idle", 32'(g_ina), 0);
      chk("vec_g_rnd_idle", 32'(g_rnd), 0);
      tick();
      chk("vec_rsp_valid_a3", 32'(rsp_valid), 0);
      tick();
      chk("vec_rsp_valid_a4", 32'(rsp_valid), 1);
      chk("vec_rsp_id", 32'(rsp_id), 32'(vt[i].id));
      chk("vec_rsp_xor", 32'(^rsp_data), 32'(vt[i].exp_x));
    end
    tick();
    chk("vec_drained", 32'(rsp_valid), 0);

    // Both requesters continuously valid: grants alternate starting at 0.
    do_reset();
    iss_ids.delete();
    rsp_ids.delete();
    req_valid = 2'b11;
    req_ina   = 4'b1001;
    req_inb   = 4'b0110;
    rnd_in    = 1'b1;
    rnd_valid = 1'b1;
    for (int c = 0; c < 12; c++) begin
      #1;
      if (c == 3) chk("alt_rsp_valid_c3", 32'(rsp_valid), 0);
      if (c == 4) begin
        chk("alt_rsp_valid_c4", 32'(rsp_valid), 1);
        chk("alt_rsp_id_c4", 32'(rsp_id), 0);
      end
      tick();
    end
    idle_inputs();
    repeat (8) tick();
    chk("alt_issue_count", 32'(iss_ids.size() >= 4), 1);
    chk("alt_rsp_count", 32'(rsp_ids.size() >= 4), 1);
    if (iss_ids.size() >= 4 && rsp_ids.size() >= 4)
      for (int k = 0; k < 4; k++) begin
        chk("alt_iss_id", 32'(iss_ids[k]), 32'(k % 2));
        chk("alt_rsp_id", 32'(rsp_ids[k]), 32'(k % 2));
      end

    // No randomness: nothing issues; raising rnd_valid issues the same cycle.
    req_valid = 2'b11;
    req_ina   = 4'b1010;
    rnd_valid = 1'b0;
    #1;
    chk("nornd_req_ready", 32'(req_ready), 0);
    chk("nornd_rnd_ready", 32'(rnd_ready), 0);
    tick();
    chk("nornd_g_ina", 32'(g_ina), 0);
    rnd_valid = 1'b1;
    #1;
    chk("rnd_up_rnd_ready", 32'(rnd_ready), 1);
    chk("rnd_up_any_ready", 32'(req_ready != 2'b00), 1);
    tick();
    idle_inputs();
    repeat (8) tick();

    // Backpressure: exactly FIFO_DEPTH issues, then drain in order and resume.
    base_iss  = issues;
    base_rsp  = rsp_ids.size();
    rsp_ready = 1'b0;
    req_valid = 2'b11;
    req_ina   = 4'b1110;
    req_inb   = 4'b0111;
    rnd_valid = 1'b1;
    repeat (12) tick();
    chk("bp_issue_count", 32'(issues - base_iss), 4);
    chk("bp_req_ready", 32'(req_ready), 0);
    chk("bp_rsp_valid", 32'(rsp_valid), 1);
    rsp_ready = 1'b1;
    repeat (10) tick();
    chk("bp_drained", 32'(rsp_ids.size() - base_rsp >= 4), 1);
    chk("bp_resumed", 32'(issues - base_iss > 4), 1);
    idle_inputs();
    repeat (10) tick();
    chk("bp_queue_empty", 32'(exp_q.size()), 0);

    // Random traffic with backpressure; the scoreboard checks every result.
    base_iss = issues;
    base_rnd = rnds;
    cyc = 0;
    while ((issues - base_iss) < 1000 && cyc < 20000) begin
      req_valid = 2'($urandom_range(0, 3));
      req_ina   = 4'($urandom_range(0, 15));
      req_inb   = 4'($urandom_range(0, 15));
      rnd_in    = 1'($urandom_range(0, 1));
      rnd_valid = ($urandom_range(0, 3) != 0);
      rsp_ready = ($urandom_range(0, 3) != 0);
      tick();
      cyc++;
    end
    chk("rand_job_budget", 32'((issues - base_iss) >= 1000), 1);
    idle_inputs();
    rsp_ready = 1'b1;
    repeat (10) tick();
    chk("rand_queue_empty", 32'(exp_q.size()), 0);
    chk("rand_rnd_count", 32'(rnds - base_rnd), 32'(issues - base_iss));

    // Reset with three jobs in flight.
    tick();
    drive_job(0, 2'b10, 2'b01, 1'b1);
    repeat (3) tick();
    #1;
    chk("mid_g_ina_live", 32'(g_ina), 32'(2'b10));
    rst_n = 1'b0;
    #1;
    chk("mid_rst_g_ina", 32'(g_ina), 0);
    chk("mid_rst_g_inb", 32'(g_inb), 0);
    chk("mid_rst_g_rnd", 32'(g_rnd), 0);
    chk("mid_rst_rsp_valid", 32'(rsp_valid), 0);
    chk("mid_rst_req_ready", 32'(req_ready), 0);
    chk("mid_rst_rnd_ready", 32'(rnd_ready), 0);
    tick();
    tick();
    idle_inputs();
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick();
      chk("post_rst_no_rsp", 32'(rsp_valid), 0);
    end
    drive_job(1, 2'b01, 2'b10, 1'b0);
    #1;
    chk("post_rst_req_ready", 32'(req_ready), 32'(2'b10));
    tick();
    idle_inputs();
    chk("post_rst_g_ina", 32'(g_ina), 32'(2'b01));
    tick();
    chk("post_rst_g_inb", 32'(g_inb), 32'(2'b10));
    tick();
    chk("post_rst_rsp_a3", 32'(rsp_valid), 0);
    tick();
    chk("post_rst_rsp_a4", 32'(rsp_valid), 1);
    chk("post_rst_rsp_id", 32'(rsp_id), 1);
    chk("post_rst_rsp_xor", 32'(^rsp_data), 1);
    repeat (4) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/msk_hpc2_and_sched.md
Name: msk_hpc2_and_sched

Overview:
- Scheduler that shares one cross-domain HPC2 masked AND gadget (d shares, latency 2) between N_REQ requesters.
- Performs round-robin arbitration and pairs each issue with fresh randomness from the PRNG handshake.
- Applies the gadget's input skew: ina at latency 0, inb one cycle later.
- Tags in-flight jobs and returns each result, with its requester id, through a credit-protected output FIFO.

Parameters:
- d, 2, number of shares per sharing.
- N_REQ, 2, number of requesters (≥2).
- FIFO_DEPTH, 4, output FIFO entries (≥4, power of two).
- RND_W, d*(d-1)/2, randomness bits consumed per gadget invocation.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  N_REQ  per-requester job valid.
- req_ready  out  N_REQ  per-requester job accepted.
- req_ina  in  N_REQ*d  sharing a; requester i occupies slice [i*d +: d].
- req_inb  in  N_REQ*d  sharing b, presented in the same cycle as req_ina.
- rnd_valid  in  1  fresh randomness available.
- rnd_ready  out  1  randomness consumed this cycle.
- rnd_in  in  RND_W  randomness word.
- g_ina  out  d  gadget input a (registered).
- g_inb  out  d  gadget input b (registered, one cycle after g_ina).
- g_rnd  out  RND_W  gadget randomness (registered, aligned with g_ina).
- g_out  in  d  gadget output sharing.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer accepts result.
- rsp_id  out  clog2(N_REQ)  originating requester.
- rsp_data  out  d  result sharing.

Behaviour:
- Reset (rst_n low, asynchronous):
  - g_ina, g_inb, g_rnd, rsp_data and rsp_id reset to 0; rsp_valid reset to 0.
  - req_ready and rnd_ready are forced to 0 while rst_n is low.
  - Pipeline valid bits cleared, FIFO emptied, round-robin pointer = 0.
- Arbitration:
  - grant = first i with req_valid[i]=1, searching from pointer upward with wrap.
  - credit = (inflight + fifo_count) < FIFO_DEPTH. This is conservative: a dequeue in the same cycle is ignored.
  - issue = any grant & rnd_valid & credit.
  - req_ready[i] = grant[i] & rnd_valid & credit; rnd_ready = issue.
  - On issue, pointer <= granted index + 1 (mod N_REQ). Pointer is unchanged otherwise.
- Timing, for a job accepted in cycle A:
  - Cycle A+1: g_ina = sharing a, g_rnd = rnd_in. The inb sharing and id are held in stage registers.
  - Cycle A+2: g_inb = sharing b.
  - Cycle A+3: g_out is valid and is captured into the FIFO at the end of the cycle, with its id.
  - Cycle A+4: earliest rsp_valid.
  - Issue is fully pipelined: one job per cycle sustained when credit allows.
- Idle hygiene: on cycles without a corresponding issue, g_ina/g_rnd (stage 1) and g_inb (stage 2) are driven to all-zero. Stale shares are never re-presented to the gadget.
- inflight = number of set valid bits across the 3 tag stages (A+1..A+3), range 0..3.
- FIFO:
  - First-word fall-through; rsp_valid = !empty.
  - Pop on rsp_valid & rsp_ready.
  - Simultaneous push and pop when full cannot occur (guaranteed by credit).
  - Simultaneous push/pop at any other occupancy leaves the count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- Results are returned in issue order. rsp_id always matches the requester whose job produced rsp_data.
- Randomness word consumed exactly once per issue; never reused, never consumed without an issue.
- A requester that holds req_valid is served within N_REQ issues.
- Reset mid-operation: in-flight jobs and buffered results are discarded. The first post-reset issue behaves as from cold reset.

Test Plan:
- Single job (d=2, N_REQ=2): req0 with ina=2'b10 (a=1), inb=2'b01 (b=1), rnd_in=1'b1 accepted in cycle 0 -> g_ina=2'b10 and g_rnd=1 in cycle 1; g_inb=2'b01 in cycle 2; rsp_valid in cycle 4 with rsp_id=0 and XOR(rsp_data)=1. Repeat with b=0 -> XOR(rsp_data)=0.
- Both requesters valid continuously, rnd_valid=1, rsp_ready=1 -> grants alternate 0,1,0,1; one issue per cycle; rsp_id sequence 0,1,0,1 starting in cycle 4.
- rnd_valid=0 while req_valid=1 -> req_ready=0 and rnd_ready=0, g_ina=0. Raising rnd_valid -> issue in that same cycle.
- rsp_ready=0 with continuous requests -> exactly FIFO_DEPTH issues, then req_ready=0. Raising rsp_ready -> all 4 results drain in order; issue resumes once credit frees.
- Random shares and rnd over 1000 jobs with random rsp_ready backpressure -> every XOR(rsp_data) equals a&b for its job; no reordering; rnd count equals issue count.
- rst_n pulsed low while 3 jobs are in flight -> outputs immediately at reset values; no rsp_valid afterwards until a new issue, which then completes 4 cycles later.
